// File: rtl/ma_pkg.sv
// Shared constants, select encodings and window helpers for the moving-average tile.
// Optional build macro MA_ROUND_EN switches the average from floor to round-half-up.
package ma_pkg;

    localparam int DATA_W   = 10;
    localparam int MAX_TAPS = 16;
    localparam int SUM_W    = 14;

    localparam logic [7:0] UIO_OE_MASK = 8'h32;

    typedef enum logic [1:0] {
        SEL_N1  = 2'b00,
        SEL_N4  = 2'b01,
        SEL_N8  = 2'b10,
        SEL_N16 = 2'b11
    } sel_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              strobe;
    } out_t;

    // log2 of the window length, used as the divide-by-N shift.
    function automatic logic [2:0] sel_shift(input sel_e sel);
        logic [2:0] sh;
        sh = 3'd0;
        unique case (sel)
            SEL_N1:  sh = 3'd0;
            SEL_N4:  sh = 3'd2;
            SEL_N8:  sh = 3'd3;
            SEL_N16: sh = 3'd4;
            default: sh = 3'd0;
        endcase
        return sh;
    endfunction

    // Half of N, added before the shift when rounding; zero when truncating.
    function automatic logic [SUM_W-1:0] round_bias(input sel_e sel);
        logic [SUM_W-1:0] bias;
        bias = '0;
`ifdef MA_ROUND_EN
        unique case (sel)
            SEL_N1:  bias = SUM_W'(0);
            SEL_N4:  bias = SUM_W'(2);
            SEL_N8:  bias = SUM_W'(4);
            SEL_N16: bias = SUM_W'(8);
            default: bias = '0;
        endcase
`else
        bias = '0;
`endif
        return bias;
    endfunction

endpackage

// File: rtl/ma_strobe_sync.sv
// Two-flop synchroniser for the asynchronous strobe plus a rising-edge detector.
// Emits a one-cycle cap pulse per strobe rise while the tile is enabled.
module ma_strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_in,
    input  logic ena,
    output logic cap
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = strobe_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // s3 keeps tracking s2 while disabled, so re-enabling on a held-high strobe does not fire.
    assign cap = s2_q & ~s3_q & ena;

endmodule

// File: rtl/tt_um_moving_average_master.sv
// TinyTapeout tile: selectable 1/4/8/16-tap moving average of a 10-bit sample stream.
// Build macro MA_ROUND_EN selects round-half-up instead of floor for the average.
module tt_um_moving_average_master
    import ma_pkg::*;
#(
    parameter int DATA_W   = ma_pkg::DATA_W,
    parameter int MAX_TAPS = ma_pkg::MAX_TAPS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [DATA_W-1:0] data_in;
    logic              strobe_in;
    sel_e              sel;

    assign data_in   = {uio_in[3:2], ui_in};
    assign strobe_in = uio_in[0];
    assign sel       = sel_e'(uio_in[7:6]);

    logic cap;

    ma_strobe_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .strobe_in (strobe_in),
        .ena       (ena),
        .cap       (cap)
    );

    logic [DATA_W-1:0] hist_q [MAX_TAPS];
    logic [DATA_W-1:0] hist_d [MAX_TAPS];
    logic              upd_q, upd_d;
    out_t              out_q, out_d;

    always_comb begin
        hist_d = hist_q;
        if (cap) begin
            hist_d[0] = data_in;
            for (int i = 1; i < MAX_TAPS; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    // Partial sums are nested so the 4-, 8- and 16-tap windows share one adder chain.
    logic [SUM_W-1:0] sum4, sum8, sum16, sum_sel, avg_full;

    // NOTE: combinational accumulation uses blocking assignments, with every output defaulted first so no latch forms.
    always_comb begin
        sum4 = '0;
        for (int i = 0; i < 4; i++) begin
            sum4 = sum4 + SUM_W'(hist_q[i]);
        end
        sum8 = sum4;
        for (int i = 4; i < 8; i++) begin
            sum8 = sum8 + SUM_W'(hist_q[i]);
        end
        sum16 = sum8;
        for (int i = 8; i < 16; i++) begin
            sum16 = sum16 + SUM_W'(hist_q[i]);
        end
    end

    always_comb begin
        sum_sel = '0;
        unique case (sel)
            SEL_N1:  sum_sel = SUM_W'(hist_q[0]);
            SEL_N4:  sum_sel = sum4;
            SEL_N8:  sum_sel = sum8;
            SEL_N16: sum_sel = sum16;
            default: sum_sel = '0;
        endcase
        avg_full = (sum_sel + round_bias(sel)) >> sel_shift(sel);
    end

    // The output follows the capture by one clock so the average sees the freshly shifted history.
    always_comb begin
        upd_d        = cap;
        out_d.strobe = upd_q;
        out_d.data   = upd_q ? avg_full[DATA_W-1:0] : out_q.data;
    end

    // NOTE: the history array is reset because warm-up must average against zeros after every reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '{default: '0};
            upd_q  <= 1'b0;
            out_q  <= '0;
        end else begin
            hist_q <= hist_d;
            upd_q  <= upd_d;
            out_q  <= out_d;
        end
    end

    assign uo_out  = out_q.data[7:0];
    assign uio_out = {2'b00, out_q.data[9:8], 2'b00, out_q.strobe, 1'b0};
    assign uio_oe  = UIO_OE_MASK;

    logic unused_ok;
    assign unused_ok = &{1'b0, uio_in[5:4], uio_in[1], avg_full[SUM_W-1:DATA_W]};

endmodule

// File: tb/tb_tt_um_moving_average_master.sv
// Self-checking bench for tt_um_moving_average_master: sample-history model plus directed vectors.
// Honours MA_ROUND_EN the same way as the design build.
module tb_tt_um_moving_average_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    tt_um_moving_average_master dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    // Behavioural model: newest sample first, average of the first N entries.
    int       hist_m [16];
    int       due      = -1;
    int       pend     = 0;
    int       exp_data = 0;
    int       pulses   = 0;
    logic [9:0] cur_d  = '0;
    logic [1:0] cur_sel = 2'b00;
    logic       strb   = 1'b0;

    function automatic int model_avg(input logic [1:0] s);
        int n, sum;
        case (s)
            2'b00:   n = 1;
            2'b01:   n = 4;
            2'b10:   n = 8;
            default: n = 16;
        endcase
        sum = 0;
        for (int i = 0; i < n; i++) sum += hist_m[i];
`ifdef MA_ROUND_EN
        return (sum + n / 2) / n;
`else
        return sum / n;
`endif
    endfunction

    function automatic logic [9:0] dout();
        return {uio_out[5:4], uo_out};
    endfunction

    task automatic drive_pins();
        logic [2:0] r;
        r      = 3'($urandom);
        ui_in  = cur_d[7:0];
        uio_in = {cur_sel, r[2:1], cur_d[9:8], r[0], strb};
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            if (edge_cnt == due) exp_data = pend;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) hist_m[i] = 0;
        exp_data = 0;
        due      = -1;
    endtask

    task automatic model_capture(input logic [9:0] d);
        for (int i = 15; i > 0; i--) hist_m[i] = hist_m[i-1];
        hist_m[0] = int'(d);
        pend = model_avg(cur_sel);
        due  = edge_cnt + 4;
    endtask

    task automatic send(input logic [9:0] d, input int hold);
        cur_d = d;
        strb  = 1'b1;
        drive_pins();
        if (ena) model_capture(d);
        step(hold);
        strb = 1'b0;
        drive_pins();
        step(4);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_async_data", 32'(dout()), 32'd0);
        check("reset_async_strobe", 32'(uio_out[1]), 32'd0);
        model_reset();
        strb = 1'b0;
        drive_pins();
        step(3);
        rst_n = 1'b1;
        step(3);
    endtask

    // Per-cycle comparison against the model, on the inactive clock edge.
    always @(negedge clk) begin
        check("strobe_out", 32'(uio_out[1]), 32'(edge_cnt == due));
        check("data_out", 32'(dout()), 32'(exp_data));
        check("uio_out_zero_bits", 32'(uio_out & 8'hCD), 32'd0);
        check("uio_oe", 32'(uio_oe), 32'h32);
        if (uio_out[1] === 1'b1) pulses++;
    end

    int exp16 [16];
    int p0;

    initial begin
`ifdef MA_ROUND_EN
        exp16 = '{63, 125, 188, 250, 313, 375, 438, 500, 563, 625, 688, 750, 813, 875, 938, 1000};
`else
        exp16 = '{62, 125, 187, 250, 312, 375, 437, 500, 562, 625, 687, 750, 812, 875, 937, 1000};
`endif
        model_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'($urandom);
        uio_in = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            ui_in  = 8'($urandom);
            uio_in = 8'($urandom);
            check("rst_uo_out", 32'(uo_out), 32'd0);
            check("rst_uio_out", 32'(uio_out), 32'd0);
            check("rst_uio_oe", 32'(uio_oe), 32'h32);
        end
        strb = 1'b0;
        drive_pins();
        step(2);
        rst_n = 1'b1;
        step(5);
        check("idle_after_reset", 32'(dout()), 32'd0);

        // Pass-through.
        cur_sel = 2'b00;
        send(10'h2A5, 2);
        check("pass_2a5", 32'(dout()), 32'h2A5);

        // 16-tap fill from a clean history.
        do_reset();
        cur_sel = 2'b11;
        for (int k = 0; k < 16; k++) begin
            send(10'd1000, 2);
            check($sformatf("fill16_k%0d", k + 1), 32'(dout()), 32'(exp16[k]));
        end

        // 4-tap window on 0,0,0,1023.
        cur_sel = 2'b01;
        send(10'd0, 2);
        send(10'd0, 2);
        send(10'd0, 2);
        send(10'd1023, 2);
`ifdef MA_ROUND_EN
        check("avg4_1023", 32'(dout()), 32'd256);
`else
        check("avg4_1023", 32'(dout()), 32'd255);
`endif

        // Strobe held high for 20 clocks gives exactly one update.
        p0 = pulses;
        send(10'h155, 20);
        check("held_one_pulse", 32'(pulses - p0), 32'd1);
        check("held_avg", 32'(dout()), 32'd341);

        // Disabled tile ignores strobes.
        ena = 1'b0;
        p0  = pulses;
        for (int i = 0; i < 3; i++) send(10'd777, 2);
        check("ena0_no_pulse", 32'(pulses - p0), 32'd0);
        check("ena0_hold", 32'(dout()), 32'd341);
        ena = 1'b1;
        step(3);

        // Fill at N=8, then reset with a sample in flight.
        cur_sel = 2'b10;
        for (int i = 0; i < 8; i++) send(10'd800, 2);
        check("fill8_800", 32'(dout()), 32'd800);
        cur_d = 10'd300;
        strb  = 1'b1;
        drive_pins();
        step(3);
        p0 = pulses;
        do_reset();
        check("reset_abort_pulse", 32'(pulses - p0), 32'd0);

        send(10'd800, 2);
        check("post_reset_800", 32'(dout()), 32'd100);
        cur_sel = 2'b00;
        drive_pins();
        send(10'd200, 2);
        check("sel_change_200", 32'(dout()), 32'd200);

        step(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
